// File: rtl/change_dispenser.sv
// change_dispenser
//
// Sits between the vending-machine controller and the physical coin ejector.
// The controller reports coins to return on `change` as a nonzero value; the
// value is added to a saturating coin counter on every cycle it is nonzero.
// The block then drives the ejector one coin at a time over a
// request/acknowledge handshake and latches a sticky fault when the ejector
// stops answering.
//
// Handshake: eject is a level request. It rises when the block starts a coin
// and stays high until the first rising edge of clk at which ack=1 is
// sampled; that edge consumes exactly one coin and drops eject. ack sampled
// while eject is low is ignored. A held ack therefore counts once per request.
// If ack has not been seen by the ACK_TIMEOUT-th edge of a request, eject
// drops and the block parks in a terminal fault state until rst.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset, clears everything
//   change   in   3  coins to add this cycle (0 = no request)
//   ack      in   1  ejector has dispensed one coin
//   eject    out  1  coin-eject request (registered)
//   pending  out  4  coins still owed, saturates at 15 (registered)
//   busy     out  1  coins owed or state machine not idle (registered)
//   fault    out  1  sticky ejector timeout (registered)
//   ovf      out  1  sticky pending saturation (registered)
//
// Parameters
//   GAP_CYC      minimum low cycles between one eject and the next (>= 1)
//   ACK_TIMEOUT  maximum cycles eject may stay high without ack (>= 2)

module change_dispenser #(
  parameter int GAP_CYC     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] change,
  input  logic       ack,
  output logic       eject,
  output logic [3:0] pending,
  output logic       busy,
  output logic       fault,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EJECT = 2'd1,
    S_GAP   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // One timer serves both the eject window and the inter-coin gap, so it is
  // sized for the longer of the two.
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] EJECT_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  // Named state register, kept at module scope so checkers can bind to it.
  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;

  logic            dec;
  logic [4:0]      sum;
  logic [3:0]      pending_next;
  logic            eject_next;
  logic            busy_next;
  logic            fault_next;
  logic            ovf_next;

  // Next-state, counter and output logic.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    dec          = 1'b0;
    sum          = 5'd0;
    pending_next = pending;
    eject_next   = 1'b0;
    busy_next    = 1'b0;
    fault_next   = fault;
    ovf_next     = ovf;

    case (state)
      S_IDLE: begin
        timer_next = '0;
        // Decision uses the registered count, so a request captured at one
        // edge raises eject at the following edge.
        if (pending != 4'd0) begin
          state_next = S_EJECT;
        end
      end

      S_EJECT: begin
        // timer holds the number of EJECT edges already survived; ack on the
        // last permitted edge still wins over the timeout.
        if (ack) begin
          dec        = 1'b1;
          timer_next = '0;
          state_next = S_GAP;
        end else if (timer == EJECT_LAST) begin
          timer_next = '0;
          state_next = S_FAULT;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end

      S_GAP: begin
        if (timer == GAP_LAST) begin
          timer_next = '0;
          state_next = S_IDLE;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end

      S_FAULT: begin
        timer_next = '0;
      end

      default: begin
        timer_next = '0;
        state_next = S_IDLE;
      end
    endcase

    // dec only happens in EJECT, which is entered only with pending >= 1,
    // so the subtraction cannot wrap. Max sum is 15 + 7 = 22, fits 5 bits.
    sum          = {1'b0, pending} - {4'b0000, dec} + {2'b00, change};
    pending_next = sum[4] ? 4'hF : sum[3:0];
    ovf_next     = ovf | sum[4];

    eject_next   = (state_next == S_EJECT);
    fault_next   = fault | (state_next == S_FAULT);
    busy_next    = (pending_next != 4'd0) | (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      eject   <= 1'b0;
      pending <= 4'd0;
      busy    <= 1'b0;
      fault   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      eject   <= eject_next;
      pending <= pending_next;
      busy    <= busy_next;
      fault   <= fault_next;
      ovf     <= ovf_next;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser.
//
// The reference model describes the block in terms of time: the cycle an
// eject request rose, the cycle from which the dispenser is idle again, and
// an integer coin count clamped at 15. Every clock edge the model is advanced
// with the same inputs the DUT saw, and all outputs are compared 1 ns after
// the edge. Directed scenarios come first, then a randomized run.

module tb_change_dispenser;

  localparam int GAP_CYC     = 2;
  localparam int ACK_TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] change;
  logic       ack;
  logic       eject;
  logic [3:0] pending;
  logic       busy;
  logic       fault;
  logic       ovf;

  always #5 clk = ~clk;

  change_dispenser #(
    .GAP_CYC    (GAP_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .change (change),
    .ack    (ack),
    .eject  (eject),
    .pending(pending),
    .busy   (busy),
    .fault  (fault),
    .ovf    (ovf)
  );

  // ---------------- bookkeeping ----------------
  int compared   = 0;
  int mismatched = 0;

  // ---------------- reference model state ----------------
  int t         = 0;   // edge index
  int m_pend    = 0;
  bit m_ej      = 1'b0;
  bit m_fault   = 1'b0;
  bit m_ovf     = 1'b0;
  bit m_busy    = 1'b0;
  int rise      = 0;   // edge at which the current request rose
  int idle_from = 0;   // edge from which the dispenser is idle again

  // ack generation: 0 = never, 1 = answer ack_delay cycles after rise,
  // 2 = drive raw_ack regardless of eject
  int ack_mode   = 0;
  int ack_delay  = 2;
  bit rand_delay = 1'b0;
  bit raw_ack    = 1'b0;

  // observation counters
  int   rises    = 0;
  int   high_cyc = 0;
  logic prev_ej  = 1'b0;

  // scoreboard of expected successive pending values
  logic [3:0] exp_q[$];
  logic [3:0] last_pend = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one edge with the sampled inputs.
  task automatic model(input int ch, input bit a, input bit r);
    int d;
    int s;
    if (r) begin
      m_pend    = 0;
      m_ej      = 1'b0;
      m_fault   = 1'b0;
      m_ovf     = 1'b0;
      idle_from = t;
    end else begin
      d = 0;
      if (m_ej) begin
        if (a) begin
          d         = 1;
          m_ej      = 1'b0;
          idle_from = t + GAP_CYC;
        end else if (t - rise == ACK_TIMEOUT) begin
          m_ej    = 1'b0;
          m_fault = 1'b1;
        end
      end else if (!m_fault && t > idle_from && m_pend != 0) begin
        m_ej = 1'b1;
        rise = t;
        if (rand_delay)
          ack_delay = ($urandom_range(0, 9) == 0) ? ACK_TIMEOUT + 2 : int'($urandom_range(1, 7));
      end
      s = m_pend - d + ch;
      if (s > 15) begin
        s     = 15;
        m_ovf = 1'b1;
      end
      m_pend = s;
    end
    m_busy = (m_pend != 0) || m_ej || m_fault || (t < idle_from);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [2:0] ch, input bit r);
    bit a;
    a = 1'b0;
    if (ack_mode == 1)      a = m_ej && ((t + 1) - rise >= ack_delay);
    else if (ack_mode == 2) a = raw_ack;
    change = ch;
    rst    = r;
    ack    = a;
    @(posedge clk);
    t++;
    model(int'(ch), a, r);
    #1;
    check("eject",   eject,   m_ej);
    check("pending", pending, m_pend);
    check("busy",    busy,    m_busy);
    check("fault",   fault,   m_fault);
    check("ovf",     ovf,     m_ovf);
    if (eject === 1'b1 && prev_ej !== 1'b1) rises++;
    if (eject === 1'b1) high_cyc++;
    prev_ej = eject;
    if (exp_q.size() != 0 && pending !== last_pend)
      check("pend_seq", pending, exp_q.pop_front());
    last_pend = pending;
  endtask

  task automatic start_test();
    step(3'd0, 1'b1);
    rises    = 0;
    high_cyc = 0;
    exp_q.delete();
    last_pend = pending;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ch;
    bit r;
    rst    = 1'b1;
    change = 3'd0;
    ack    = 1'b0;

    // reset state
    step(3'd0, 1'b1);
    step(3'd0, 1'b1);
    check("rst_eject",   eject,   0);
    check("rst_pending", pending, 0);
    check("rst_busy",    busy,    0);
    check("rst_fault",   fault,   0);
    check("rst_ovf",     ovf,     0);

    // single change of 3, ack two cycles after each rise
    start_test();
    ack_mode  = 1;
    ack_delay = 2;
    exp_q     = '{4'd3, 4'd2, 4'd1, 4'd0};
    step(3'd3, 1'b0);
    check("t1_capture", pending, 3);
    check("t1_no_eject_yet", eject, 0);
    step(3'd0, 1'b0);
    check("t1_rise", eject, 1);
    repeat (20) step(3'd0, 1'b0);
    check("t1_pulses", rises, 3);
    check("t1_busy_done", busy, 0);
    check("t1_seq_done", exp_q.size(), 0);

    // accumulate while busy: ack and change=4 on the same edge with pending=2
    start_test();
    ack_mode  = 1;
    ack_delay = 2;
    step(3'd2, 1'b0);
    step(3'd0, 1'b0);
    step(3'd0, 1'b0);
    step(3'd4, 1'b0);
    check("t2_add_and_dec", pending, 5);
    repeat (40) step(3'd0, 1'b0);
    check("t2_pulses", rises, 6);
    check("t2_pending_done", pending, 0);

    // saturation: four changes of 4 with the ejector silent
    start_test();
    ack_mode = 0;
    exp_q    = '{4'd4, 4'd8, 4'd12, 4'd15};
    repeat (4) step(3'd4, 1'b0);
    check("t3_sat", pending, 15);
    check("t3_ovf", ovf, 1);
    ack_mode  = 1;
    ack_delay = 2;
    repeat (100) step(3'd0, 1'b0);
    check("t3_pulses", rises, 15);
    check("t3_ovf_sticky", ovf, 1);
    check("t3_seq_done", exp_q.size(), 0);

    // timeout: ack never arrives
    start_test();
    ack_mode = 0;
    step(3'd1, 1'b0);
    repeat (25) step(3'd0, 1'b0);
    check("t4_high_cycles", high_cyc, ACK_TIMEOUT);
    check("t4_fault", fault, 1);
    check("t4_pending_kept", pending, 1);
    step(3'd2, 1'b0);
    check("t4_accum_in_fault", pending, 3);
    repeat (5) step(3'd0, 1'b0);
    check("t4_no_more_ejects", rises, 1);
    step(3'd0, 1'b1);
    check("t4_rst_fault", fault, 0);
    check("t4_rst_pending", pending, 0);
    check("t4_rst_busy", busy, 0);

    // ack exactly on the last permitted edge
    start_test();
    ack_mode  = 1;
    ack_delay = ACK_TIMEOUT;
    step(3'd1, 1'b0);
    repeat (25) step(3'd0, 1'b0);
    check("t5_high_cycles", high_cyc, ACK_TIMEOUT);
    check("t5_no_fault", fault, 0);
    check("t5_pending", pending, 0);

    // reset in the middle of a request
    start_test();
    ack_mode = 0;
    step(3'd3, 1'b0);
    step(3'd0, 1'b0);
    step(3'd0, 1'b0);
    check("t6_in_flight", eject, 1);
    check("t6_pending3", pending, 3);
    step(3'd0, 1'b1);
    check("t6_eject_cleared", eject, 0);
    check("t6_pending_cleared", pending, 0);
    ack_mode = 2;
    raw_ack  = 1'b1;
    repeat (5) step(3'd0, 1'b0);
    check("t6_ack_ignored", pending, 0);
    check("t6_no_eject", rises, 1);

    // ack held high: one coin per request
    start_test();
    ack_mode = 2;
    raw_ack  = 1'b1;
    step(3'd2, 1'b0);
    repeat (15) step(3'd0, 1'b0);
    check("t7_pulses", rises, 2);
    check("t7_pending", pending, 0);

    // randomized traffic
    start_test();
    ack_mode   = 1;
    rand_delay = 1'b1;
    ack_delay  = 3;
    repeat (800) begin
      ch = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r  = ($urandom_range(0, 149) == 0);
      step(ch, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
